// File: rtl/qoa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : qoa_pkg
//  Purpose  : Shared constants and helpers for the QOA residual quantizer:
//             FSM state encoding, scalefactor reciprocals, the residual to
//             code mapping, the dequantization table and a 16-bit clamp.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package qoa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESID = 3'd1,
        ST_MUL   = 3'd2,
        ST_ROUND = 3'd3,
        ST_RECON = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Fixed-point 1/scalefactor in Q16; entry 0 is exactly 1.0 and needs 17 bits.
    localparam logic [16:0] c_recip_tab [16] = '{
        17'd65536, 17'd9363, 17'd3121, 17'd1457, 17'd781, 17'd475, 17'd311, 17'd216,
        17'd156,   17'd117,  17'd90,   17'd71,   17'd57,  17'd47,  17'd39,  17'd32
    };

    // Indexed by the clamped scaled residual plus 8 (range -8..8).
    localparam logic [2:0] c_quant_tab [17] = '{
        3'd7, 3'd7, 3'd7, 3'd5, 3'd5, 3'd3, 3'd3, 3'd1, 3'd0,
        3'd0, 3'd2, 3'd2, 3'd4, 3'd4, 3'd6, 3'd6, 3'd6
    };

    localparam logic signed [15:0] c_dequant_tab [16][8] = '{
        '{16'sd1,    -16'sd1,    16'sd3,    -16'sd3,    16'sd5,    -16'sd5,    16'sd7,     -16'sd7},
        '{16'sd5,    -16'sd5,    16'sd18,   -16'sd18,   16'sd32,   -16'sd32,   16'sd49,    -16'sd49},
        '{16'sd16,   -16'sd16,   16'sd53,   -16'sd53,   16'sd95,   -16'sd95,   16'sd147,   -16'sd147},
        '{16'sd34,   -16'sd34,   16'sd113,  -16'sd113,  16'sd203,  -16'sd203,  16'sd315,   -16'sd315},
        '{16'sd63,   -16'sd63,   16'sd210,  -16'sd210,  16'sd378,  -16'sd378,  16'sd588,   -16'sd588},
        '{16'sd104,  -16'sd104,  16'sd345,  -16'sd345,  16'sd621,  -16'sd621,  16'sd966,   -16'sd966},
        '{16'sd158,  -16'sd158,  16'sd528,  -16'sd528,  16'sd950,  -16'sd950,  16'sd1477,  -16'sd1477},
        '{16'sd228,  -16'sd228,  16'sd760,  -16'sd760,  16'sd1368, -16'sd1368, 16'sd2128,  -16'sd2128},
        '{16'sd316,  -16'sd316,  16'sd1053, -16'sd1053, 16'sd1895, -16'sd1895, 16'sd2947,  -16'sd2947},
        '{16'sd422,  -16'sd422,  16'sd1405, -16'sd1405, 16'sd2529, -16'sd2529, 16'sd3934,  -16'sd3934},
        '{16'sd548,  -16'sd548,  16'sd1828, -16'sd1828, 16'sd3290, -16'sd3290, 16'sd5117,  -16'sd5117},
        '{16'sd696,  -16'sd696,  16'sd2320, -16'sd2320, 16'sd4176, -16'sd4176, 16'sd6496,  -16'sd6496},
        '{16'sd868,  -16'sd868,  16'sd2893, -16'sd2893, 16'sd5207, -16'sd5207, 16'sd8099,  -16'sd8099},
        '{16'sd1064, -16'sd1064, 16'sd3548, -16'sd3548, 16'sd6386, -16'sd6386, 16'sd9933,  -16'sd9933},
        '{16'sd1286, -16'sd1286, 16'sd4288, -16'sd4288, 16'sd7718, -16'sd7718, 16'sd12005, -16'sd12005},
        '{16'sd1536, -16'sd1536, 16'sd5120, -16'sd5120, 16'sd9216, -16'sd9216, 16'sd14336, -16'sd14336}
    };

    function automatic logic signed [15:0] clamp_s16(input logic signed [16:0] x);
        if (x > 17'sd32767)
            return 16'sh7FFF;
        else if (x < -17'sd32768)
            return 16'sh8000;
        else
            return $signed(x[15:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/qoa_serial_mul.sv
`default_nettype none
// ============================================================================
//  Module   : qoa_serial_mul
//  Purpose  : 17x17 unsigned shift-add multiplier retiring BITS_PER_CYCLE
//             multiplier bits per step; ceil(17/BITS_PER_CYCLE) steps.
//  Ports    : clk, rst      clock, synchronous active-high reset
//             load          capture a/b and clear the accumulator
//             step          retire the next BITS_PER_CYCLE bits of b
//             a, b          17-bit unsigned operands
//             product       34-bit running product (final once b is used up)
//             done          high during the step that retires the last bits
//  Revision : 1.0  initial release
// ============================================================================
module qoa_serial_mul #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [33:0] product,
    output logic        done
);

    localparam int         c_steps = (17 + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
    localparam logic [4:0] c_last  = 5'(c_steps - 1);

    logic [33:0] r_a;
    logic [33:0] r_acc;
    logic [16:0] r_b;
    logic [4:0]  r_cnt;
    logic [33:0] w_partial;

    always_comb begin
        w_partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_b[i])
                w_partial = w_partial + (r_a << i);
        end
    end

    // Once all multiplier bits are shifted out w_partial is zero, so this is
    // already the final product during the last step and stays valid after.
    assign product = r_acc + w_partial;
    assign done    = step && (r_cnt == c_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_a   <= {17'd0, a};
            r_b   <= b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (step) begin
            r_acc <= product;
            r_a   <= r_a << BITS_PER_CYCLE;
            r_b   <= r_b >> BITS_PER_CYCLE;
            r_cnt <= r_cnt + 5'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qoa_residual_quantizer.sv
`default_nettype none
// ============================================================================
//  Module   : qoa_residual_quantizer
//  Purpose  : QOA encoder sample quantizer. Per request: residual =
//             sample - pred, scaled by the reciprocal of the scalefactor,
//             rounded to a 3-bit code, then dequantized and reconstructed.
//  Ports    : clk, rst      clock, synchronous active-high reset
//             start         request strobe, taken only while busy=0
//             sample, pred  signed 16-bit sample and LMS prediction
//             sf            scalefactor index 0..15
//             busy          operation in progress
//             done          one-cycle pulse, results valid and held
//             q             3-bit quantized residual code
//             dequant       signed dequantized residual
//             recon         signed saturated reconstruction
//             err_sq        (sample-recon)^2, only with QOA_QUANT_ERROR_EN
//  Config   : `define QOA_QUANT_ERROR_EN adds the ERR state and err_sq port.
//  Revision : 1.0  initial release
// ============================================================================
module qoa_residual_quantizer
    import qoa_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] sample,
    input  logic [15:0] pred,
    input  logic [3:0]  sf,
    output logic        busy,
    output logic        done,
    output logic [2:0]  q,
    output logic [15:0] dequant,
    output logic [15:0] recon
`ifdef QOA_QUANT_ERROR_EN
    ,
    output logic [31:0] err_sq
`endif
);

    state_t             r_state;
    logic signed [15:0] r_sample;
    logic signed [15:0] r_pred;
    logic [3:0]         r_sf;
    logic               r_vneg;
    logic               r_vzero;
    logic [2:0]         r_qi;
`ifdef QOA_QUANT_ERROR_EN
    logic signed [15:0] r_dq;
    logic signed [15:0] r_rc;
    logic signed [16:0] w_e;
    logic [16:0]        w_e_mag;
`endif

    logic signed [16:0] w_v;
    logic [16:0]        w_v_mag;
    logic               w_mul_load;
    logic               w_mul_step;
    logic               w_mul_done;
    logic [16:0]        w_mul_a;
    logic [16:0]        w_mul_b;
    logic [33:0]        w_prod;
    logic signed [34:0] w_p;
    logic signed [34:0] w_n0;
    logic signed [34:0] w_n1;
    logic signed [34:0] w_nc;
    logic signed [34:0] w_sgn_v;
    logic signed [34:0] w_sgn_n;
    logic [4:0]         w_qidx;
    logic [2:0]         w_q;
    logic signed [15:0] w_dq;
    logic signed [16:0] w_sum;
    logic signed [15:0] w_recon;

    // Residual is at most 17 bits, so the difference never wraps.
    assign w_v     = {r_sample[15], r_sample} - {r_pred[15], r_pred};
    assign w_v_mag = w_v[16] ? 17'(-w_v) : 17'(w_v);

    // Rounding: the sign fixup nudges values that rounded toward zero so a
    // nonzero residual never maps to the zero bucket on the wrong side.
    always_comb begin
        w_p     = r_vneg ? -$signed({1'b0, w_prod}) : $signed({1'b0, w_prod});
        w_n0    = (w_p + 35'sd32768) >>> 16;
        w_sgn_v = r_vzero ? 35'sd0 : (r_vneg ? -35'sd1 : 35'sd1);
        w_sgn_n = (w_n0 == 35'sd0) ? 35'sd0 : (w_n0[34] ? -35'sd1 : 35'sd1);
        w_n1    = w_n0 + w_sgn_v - w_sgn_n;
        if (w_n1 > 35'sd8)
            w_nc = 35'sd8;
        else if (w_n1 < -35'sd8)
            w_nc = -35'sd8;
        else
            w_nc = w_n1;
        w_qidx  = 5'(w_nc + 35'sd8);
        w_q     = c_quant_tab[w_qidx];
    end

    assign w_dq    = c_dequant_tab[r_sf][r_qi];
    assign w_sum   = {r_pred[15], r_pred} + {w_dq[15], w_dq};
    assign w_recon = clamp_s16(w_sum);

`ifdef QOA_QUANT_ERROR_EN
    assign w_e     = {r_sample[15], r_sample} - {w_recon[15], w_recon};
    assign w_e_mag = w_e[16] ? 17'(-w_e) : 17'(w_e);
`endif

    // The multiplier is loaded in the cycle before each serial phase.
    always_comb begin
        w_mul_load = (r_state == ST_RESID);
        w_mul_step = (r_state == ST_MUL);
        w_mul_a    = w_v_mag;
        w_mul_b    = c_recip_tab[r_sf];
`ifdef QOA_QUANT_ERROR_EN
        if (r_state == ST_RECON) begin
            w_mul_load = 1'b1;
            w_mul_a    = w_e_mag;
            w_mul_b    = w_e_mag;
        end
        if (r_state == ST_ERR)
            w_mul_step = 1'b1;
`endif
    end

    qoa_serial_mul #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (w_mul_load),
        .step    (w_mul_step),
        .a       (w_mul_a),
        .b       (w_mul_b),
        .product (w_prod),
        .done    (w_mul_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sample <= '0;
            r_pred   <= '0;
            r_sf     <= '0;
            r_vneg   <= 1'b0;
            r_vzero  <= 1'b0;
            r_qi     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= '0;
            dequant  <= '0;
            recon    <= '0;
`ifdef QOA_QUANT_ERROR_EN
            r_dq     <= '0;
            r_rc     <= '0;
            err_sq   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sample <= $signed(sample);
                        r_pred   <= $signed(pred);
                        r_sf     <= sf;
                        busy     <= 1'b1;
                        r_state  <= ST_RESID;
                    end
                end
                ST_RESID: begin
                    r_vneg  <= w_v[16];
                    r_vzero <= (w_v == 17'sd0);
                    r_state <= ST_MUL;
                end
                ST_MUL: begin
                    if (w_mul_done)
                        r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_qi    <= w_q;
                    r_state <= ST_RECON;
                end
                ST_RECON: begin
`ifdef QOA_QUANT_ERROR_EN
                    r_dq    <= w_dq;
                    r_rc    <= w_recon;
                    r_state <= ST_ERR;
`else
                    q       <= r_qi;
                    dequant <= w_dq;
                    recon   <= w_recon;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
`endif
                end
`ifdef QOA_QUANT_ERROR_EN
                ST_ERR: begin
                    if (w_mul_done) begin
                        q       <= r_qi;
                        dequant <= r_dq;
                        recon   <= r_rc;
                        err_sq  <= (|w_prod[33:32]) ? 32'hFFFF_FFFF : w_prod[31:0];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qoa_residual_quantizer.sv
`default_nettype none
module tb_qoa_residual_quantizer;

    localparam int c_ndut = 4;
`ifdef QOA_QUANT_ERROR_EN
    localparam int c_passes = 2;
`else
    localparam int c_passes = 1;
`endif

    localparam int c_recip [16] = '{65536, 9363, 3121, 1457, 781, 475, 311, 216,
                                    156, 117, 90, 71, 57, 47, 39, 32};
    localparam int c_quant [17] = '{7, 7, 7, 5, 5, 3, 3, 1, 0, 0, 2, 2, 4, 4, 6, 6, 6};
    localparam int c_deq [16][8] = '{
        '{1, -1, 3, -3, 5, -5, 7, -7},
        '{5, -5, 18, -18, 32, -32, 49, -49},
        '{16, -16, 53, -53, 95, -95, 147, -147},
        '{34, -34, 113, -113, 203, -203, 315, -315},
        '{63, -63, 210, -210, 378, -378, 588, -588},
        '{104, -104, 345, -345, 621, -621, 966, -966},
        '{158, -158, 528, -528, 950, -950, 1477, -1477},
        '{228, -228, 760, -760, 1368, -1368, 2128, -2128},
        '{316, -316, 1053, -1053, 1895, -1895, 2947, -2947},
        '{422, -422, 1405, -1405, 2529, -2529, 3934, -3934},
        '{548, -548, 1828, -1828, 3290, -3290, 5117, -5117},
        '{696, -696, 2320, -2320, 4176, -4176, 6496, -6496},
        '{868, -868, 2893, -2893, 5207, -5207, 8099, -8099},
        '{1064, -1064, 3548, -3548, 6386, -6386, 9933, -9933},
        '{1286, -1286, 4288, -4288, 7718, -7718, 12005, -12005},
        '{1536, -1536, 5120, -5120, 9216, -9216, 14336, -14336}
    };

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic [15:0] sample = '0;
    logic [15:0] pred   = '0;
    logic [3:0]  sf     = '0;

    logic        busy_a [c_ndut];
    logic        done_a [c_ndut];
    logic [2:0]  q_a    [c_ndut];
    logic [15:0] dq_a   [c_ndut];
    logic [15:0] rc_a   [c_ndut];
`ifdef QOA_QUANT_ERROR_EN
    logic [31:0] esq_a  [c_ndut];
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int lat0    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < c_ndut; g++) begin : g_dut
        localparam int BPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 17;
        qoa_residual_quantizer #(
            .BITS_PER_CYCLE (BPC)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start),
            .sample  (sample),
            .pred    (pred),
            .sf      (sf),
            .busy    (busy_a[g]),
            .done    (done_a[g]),
            .q       (q_a[g]),
            .dequant (dq_a[g]),
            .recon   (rc_a[g])
`ifdef QOA_QUANT_ERROR_EN
            ,
            .err_sq  (esq_a[g])
`endif
        );
    end

    function automatic int bpc_of(input int g);
        case (g)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 17;
        endcase
    endfunction

    function automatic int lat_of(input int g);
        int n;
        n = (17 + bpc_of(g) - 1) / bpc_of(g);
        return 3 + c_passes * n;
    endfunction

    function automatic string tag(input string base, input int g);
        return $sformatf("%s[bpc%0d]", base, bpc_of(g));
    endfunction

    function automatic longint sgn(input longint x);
        return (x > 0) ? 64'sd1 : (x < 0) ? -64'sd1 : 64'sd0;
    endfunction

    // Reference: plain integer arithmetic straight from the quantizer rules.
    function automatic void model(input int s, input int p, input int f,
                                  output int eq, output int edq, output int erc,
                                  output longint eesq);
        longint v, pr, n, e;
        v  = s - p;
        pr = v * c_recip[f];
        n  = (pr + 32768) >>> 16;
        n  = n + sgn(v) - sgn(n);
        if (n > 8)  n = 8;
        if (n < -8) n = -8;
        eq  = c_quant[n + 8];
        edq = c_deq[f][eq];
        erc = p + edq;
        if (erc > 32767)  erc = 32767;
        if (erc < -32768) erc = -32768;
        e    = s - erc;
        eesq = e * e;
        if (eesq > 64'sd4294967295) eesq = 64'sd4294967295;
    endfunction

    task automatic check(input string name, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic check_outputs(input string pfx, input int i, input int eq, input int edq,
                                 input int erc, input longint eesq);
        check(tag({pfx, "q"}, i), longint'(q_a[i]), eq);
        check(tag({pfx, "dequant"}, i), longint'($signed(dq_a[i])), edq);
        check(tag({pfx, "recon"}, i), longint'($signed(rc_a[i])), erc);
`ifdef QOA_QUANT_ERROR_EN
        check(tag({pfx, "err_sq"}, i), longint'(esq_a[i]), eesq);
`endif
    endtask

    task automatic check_zero(input string pfx);
        for (int i = 0; i < c_ndut; i++) begin
            check(tag({pfx, "busy"}, i), longint'(busy_a[i]), 0);
            check(tag({pfx, "done"}, i), longint'(done_a[i]), 0);
            check_outputs(pfx, i, 0, 0, 0, 0);
        end
    endtask

    // Called at a negedge; the next posedge samples start. Back-to-back calls
    // issue the new start in the done cycle of the slowest instance.
    task automatic run_vec(input int s, input int p, input int f);
        int     eq, edq, erc, cyc, nseen;
        longint eesq;
        bit     seen [c_ndut];
        model(s, p, f, eq, edq, erc, eesq);
        sample = 16'(s);
        pred   = 16'(p);
        sf     = 4'(f);
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        nseen = 0;
        cyc   = 0;
        for (int i = 0; i < c_ndut; i++) seen[i] = 1'b0;
        while (nseen < c_ndut && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            for (int i = 0; i < c_ndut; i++) begin
                if (!seen[i] && done_a[i]) begin
                    seen[i] = 1'b1;
                    nseen++;
                    if (i == 0) lat0 = cyc;
                    check(tag("latency", i), cyc, lat_of(i));
                    check(tag("busy_at_done", i), longint'(busy_a[i]), 0);
                    check_outputs("", i, eq, edq, erc, eesq);
                end
            end
        end
        for (int i = 0; i < c_ndut; i++) begin
            if (!seen[i])
                check(tag("done_timeout", i), longint'(seen[i]), 1);
            else
                check_outputs("hold_", i, eq, edq, erc, eesq);
        end
    endtask

    task automatic check_dir(input string name, input int eq, input int edq, input int erc,
                             input longint eesq);
        check({name, "_q"}, longint'(q_a[0]), eq);
        check({name, "_dequant"}, longint'($signed(dq_a[0])), edq);
        check({name, "_recon"}, longint'($signed(rc_a[0])), erc);
`ifdef QOA_QUANT_ERROR_EN
        check({name, "_err_sq"}, longint'(esq_a[0]), eesq);
        check({name, "_latency"}, lat0, 37);
`else
        check({name, "_latency"}, lat0, 20);
`endif
    endtask

    initial begin
        int           s, p, f;
        logic [15:0]  r16;
        int           pre_done  [c_ndut];
        int           post_done [c_ndut];

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_zero("reset_");

        run_vec(100, 0, 0);
        check_dir("case1", 6, 7, 7, 8649);
        run_vec(0, 0, 5);
        check_dir("case2", 0, 104, 104, 10816);
        run_vec(-32768, 32767, 15);
        check_dir("case3", 7, -14336, 18431, 64'sd2621337601);
        run_vec(32767, 32000, 15);
        check_dir("case4", 0, 1536, 32767, 0);

        for (int k = 0; k < 1000; k++) begin
            r16 = 16'($urandom);
            s   = int'($signed(r16));
            case ($urandom_range(0, 3))
                0: begin
                    p = s + int'($urandom_range(0, 600)) - 300;
                    r16 = 16'(p);
                    p = int'($signed(r16));
                end
                1: begin
                    s = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
                    p = ($urandom_range(0, 1) == 0) ? -32768 : 32767;
                end
                default: begin
                    r16 = 16'($urandom);
                    p   = int'($signed(r16));
                end
            endcase
            f = int'($urandom_range(0, 15));
            run_vec(s, p, f);
        end

        // Abort: start at edge 0, ignored start at edge 3, reset at edge 10.
        for (int i = 0; i < c_ndut; i++) begin
            pre_done[i]  = 0;
            post_done[i] = 0;
        end
        sample = 16'd1234;
        pred   = 16'd0;
        sf     = 4'd3;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < c_ndut; i++)
                if (done_a[i]) pre_done[i]++;
            if (k == 2) begin
                start  = 1'b1;
                sample = 16'd5;
            end
            if (k == 3) start = 1'b0;
            if (k == 9) rst = 1'b1;
        end
        rst = 1'b0;
        check_zero("abort_");
        for (int i = 0; i < c_ndut; i++)
            if (lat_of(i) > 10) check(tag("abort_pre_done", i), pre_done[i], 0);
        repeat (50) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < c_ndut; i++)
                if (done_a[i]) post_done[i]++;
        end
        for (int i = 0; i < c_ndut; i++)
            check(tag("abort_post_done", i), post_done[i], 0);
        check_zero("idle_");

        run_vec(100, 0, 0);
        check_dir("recover", 6, 7, 7, 8649);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
